px_uart_stream: RTL

PX_UART_STREAM -- requirements
Module: px_uart_stream

---
 rtl/px_uart_stream.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/px_uart_stream.sv
// Pixel byte stream to 8N1 UART: pixels and frame headers are queued in a small FIFO
// and serialised LSB first; 0xFF is reserved on the line as the frame marker.
module px_uart_stream #(
   parameter int CLKS_PER_BIT = 12,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    pixel_data,
   input  logic                          pixel_vld,
   input  logic                          frame_start,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic                          overflow,
   output logic [15:0]                   drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   state_t        state_q, state_d;
   logic [7:0]    bit_cnt_q, bit_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d, busy_q, busy_d;

   logic          fifo_full, fifo_empty, push_req, push, pop, bit_end;
   logic [7:0]    push_byte;
   logic [1:0]    n_drop;
   logic [16:0]   drop_sum;

   // Write side: a header always wins the slot; a pixel in the same cycle is a drop.
   always_comb begin
      fifo_full  = (level_q == LW'(FIFO_DEPTH));
      fifo_empty = (level_q == '0);
      push_req   = frame_start | pixel_vld;
      push       = push_req & ~fifo_full;
      push_byte  = frame_start ? 8'hFF : ((pixel_data == 8'hFF) ? 8'hFE : pixel_data);
      n_drop     = {1'b0, push_req & fifo_full} + {1'b0, frame_start & pixel_vld};
      drop_sum   = {1'b0, drop_cnt_q} + {15'd0, n_drop};
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow_d = overflow_q;
      if (n_drop != 2'd0) begin
         overflow_d = 1'b1;
      end else if (frame_start) begin
         overflow_d = 1'b0;
      end
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_q[wr_ptr_q] <= push_byte;
      end
   end

   // Line and busy are registered from the current state, so they trail it by one cycle.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      tx_d      = 1'b1;
      busy_d    = 1'b1;
      bit_end   = (bit_cnt_q == 8'(CLKS_PER_BIT - 1));
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               bit_cnt_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            tx_d      = 1'b0;
            bit_cnt_d = bit_end ? 8'd0 : bit_cnt_q + 8'd1;
            if (bit_end) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_d      = shift_q[0];
            bit_cnt_d = bit_end ? 8'd0 : bit_cnt_q + 8'd1;
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            bit_cnt_d = bit_end ? 8'd0 : bit_cnt_q + 8'd1;
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign uart_tx    = tx_q;
   assign tx_busy    = busy_q;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
   assign fifo_level = level_q;

endmodule
